// File: rtl/ms_pulse_countdown.sv
// ============================================================================
// Module  : ms_pulse_countdown
// Purpose : Counts 1 ms ticks into seconds and counts a BCD game timer down
//           from a loaded 00-99 value. Optional macro TENTHS_DIGIT_EN adds
//           a tenths-of-a-second digit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_pulse_countdown #(
    parameter int MS_PER_SEC = 1000,
    parameter int MS_CNT_W   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] startTens,
    input  logic [3:0] startOnes,
    input  logic       start,
    input  logic       pause,
    input  logic       msPulse,
    output logic       timerEnable,
    output logic [3:0] secTens,
    output logic [3:0] secOnes,
    output logic       running,
    output logic       done
`ifdef TENTHS_DIGIT_EN
    ,
    output logic [3:0] tenths
`endif
);

`ifdef TENTHS_DIGIT_EN
    localparam int TICKS_PER_STEP = MS_PER_SEC / 10;
`else
    localparam int TICKS_PER_STEP = MS_PER_SEC;
`endif
    localparam logic [MS_CNT_W-1:0] C_LAST_TICK = MS_CNT_W'(TICKS_PER_STEP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [3:0]          tens_q, tens_d;
    logic [3:0]          ones_q, ones_d;
    logic                timer_en_q, timer_en_d;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic                step;
    logic                time_zero;
`ifdef TENTHS_DIGIT_EN
    logic [3:0]          tenths_q, tenths_d;
`endif

    function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_comb begin
        state_d  = state_q;
        ms_cnt_d = ms_cnt_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        done_d   = 1'b0;
        step     = 1'b0;
`ifdef TENTHS_DIGIT_EN
        tenths_d  = tenths_q;
        time_zero = (tens_q == 4'd0) && (ones_q == 4'd0) && (tenths_q == 4'd0);
`else
        time_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
`endif

        if (load) begin
            tens_d   = clamp_bcd(startTens);
            ones_d   = clamp_bcd(startOnes);
            ms_cnt_d = '0;
            state_d  = IDLE;
`ifdef TENTHS_DIGIT_EN
            tenths_d = 4'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pause && start) begin
                        if (time_zero) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    // A tick arriving with pause is still counted
                    if (msPulse) begin
                        if (ms_cnt_q == C_LAST_TICK) begin
                            ms_cnt_d = '0;
                            step     = 1'b1;
                        end else begin
                            ms_cnt_d = ms_cnt_q + 1'b1;
                        end
                    end
                    if (pause) begin
                        state_d = PAUSE;
                    end
                    if (step) begin
`ifdef TENTHS_DIGIT_EN
                        if (tenths_q == 4'd0) begin
                            tenths_d = 4'd9;
                            if (ones_q == 4'd0) begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end else begin
                                ones_d = ones_q - 4'd1;
                            end
                        end else begin
                            tenths_d = tenths_q - 4'd1;
                        end
                        if ((tens_d == 4'd0) && (ones_d == 4'd0) && (tenths_d == 4'd0)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
`else
                        if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                        if ((tens_d == 4'd0) && (ones_d == 4'd0)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
`endif
                    end
                end
                PAUSE: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = DONE;
                end
            endcase
        end

        timer_en_d = (state_d == RUN);
        running_d  = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ms_cnt_q   <= '0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            timer_en_q <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef TENTHS_DIGIT_EN
            tenths_q   <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            ms_cnt_q   <= ms_cnt_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            timer_en_q <= timer_en_d;
            running_q  <= running_d;
            done_q     <= done_d;
`ifdef TENTHS_DIGIT_EN
            tenths_q   <= tenths_d;
`endif
        end
    end

    assign timerEnable = timer_en_q;
    assign secTens     = tens_q;
    assign secOnes     = ones_q;
    assign running     = running_q;
    assign done        = done_q;
`ifdef TENTHS_DIGIT_EN
    assign tenths      = tenths_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ms_pulse_countdown.sv
// ============================================================================
// Module  : tb_ms_pulse_countdown
// Purpose : Directed self-checking bench for ms_pulse_countdown.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ms_pulse_countdown;

    logic       clk = 1'b0;
    logic       rst;
    logic       load, start, pause, msPulse;
    logic [3:0] startTens, startOnes;
    logic       timerEnable, running, done;
    logic [3:0] secTens, secOnes;
`ifdef TENTHS_DIGIT_EN
    logic [3:0] tenths;
`endif

    int total = 0;
    int bad   = 0;

    ms_pulse_countdown #(
        .MS_PER_SEC(1000),
        .MS_CNT_W  (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .startTens  (startTens),
        .startOnes  (startOnes),
        .start      (start),
        .pause      (pause),
        .msPulse    (msPulse),
        .timerEnable(timerEnable),
        .secTens    (secTens),
        .secOnes    (secOnes),
        .running    (running),
        .done       (done)
`ifdef TENTHS_DIGIT_EN
        ,
        .tenths     (tenths)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulses(input int n);
        msPulse = 1'b1;
        repeat (n) cyc();
        msPulse = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        load = 1'b1; startTens = t; startOnes = o;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; msPulse = 1'b0;
        startTens = 4'd0; startOnes = 4'd0;
        #1;
        chk("rst_timerEnable", timerEnable, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_digits", {secTens, secOnes}, 8'h00);
        cyc();
        rst = 1'b0;
        cyc();

        // full countdown from 12
        do_load(4'd1, 4'd2);
        chk("t1_loaded", {secTens, secOnes}, 8'h12);
        chk("t1_idle_enable", timerEnable, 0);
        do_start();
        chk("t1_run_enable", timerEnable, 1);
        chk("t1_running", running, 1);
        pulses(1000);
        chk("t1_after_1s", {secTens, secOnes}, 8'h11);
        pulses(10999);
        chk("t1_before_end", {secTens, secOnes}, 8'h01);
        chk("t1_no_done_early", done, 0);
        pulses(1);
        chk("t1_done_pulse", done, 1);
        chk("t1_digits_zero", {secTens, secOnes}, 8'h00);
        chk("t1_enable_off", timerEnable, 0);
        chk("t1_running_off", running, 0);
        cyc();
        chk("t1_done_one_cycle", done, 0);
        pulses(1000);
        chk("t1_hold_zero", {secTens, secOnes}, 8'h00);

        // borrow from tens
        do_load(4'd1, 4'd0);
        do_start();
        pulses(1000);
        chk("t2_borrow", {secTens, secOnes}, 8'h09);
        chk("t2_enable", timerEnable, 1);
        chk("t2_no_done", done, 0);

        // pause / resume keeps partial ms count
        do_load(4'd0, 4'd2);
        do_start();
        pulses(500);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk("t3_pause_enable", timerEnable, 0);
        chk("t3_pause_running", running, 0);
        pulses(300);
        chk("t3_pause_hold", {secTens, secOnes}, 8'h02);
        pause = 1'b1; start = 1'b1;
        cyc();
        pause = 1'b0; start = 1'b0;
        chk("t3_pause_start_stays", running, 0);
        do_start();
        chk("t3_resume", running, 1);
        pulses(499);
        chk("t3_partial", {secTens, secOnes}, 8'h02);
        pulses(1);
        chk("t3_resumed_count", {secTens, secOnes}, 8'h01);

        // async reset mid-run
        do_load(4'd3, 4'd4);
        do_start();
        pulses(10);
        #2;
        rst = 1'b1;
        #1;
        chk("t4_async_enable", timerEnable, 0);
        chk("t4_async_running", running, 0);
        chk("t4_async_digits", {secTens, secOnes}, 8'h00);
        chk("t4_async_done", done, 0);
        cyc();
        rst = 1'b0;
        cyc();
        do_start();
        chk("t4_idle_zero_start", done, 1);

        // clamp, zero start, start ignored in DONE
        do_load(4'hF, 4'hF);
        chk("t5_clamp", {secTens, secOnes}, 8'h99);
        do_load(4'd0, 4'd0);
        do_start();
        chk("t5_zero_done", done, 1);
        chk("t5_zero_running", running, 0);
        cyc();
        chk("t5_done_drop", done, 0);
        do_start();
        chk("t5_done_ignore_start", done, 0);
        chk("t5_done_ignore_run", running, 0);
        do_load(4'd0, 4'd3);
        chk("t5_load_leaves_done", {secTens, secOnes}, 8'h03);
        do_start();
        chk("t5_rerun", running, 1);

`ifdef TENTHS_DIGIT_EN
        do_load(4'd0, 4'd1);
        chk("t6_tenths_clear", tenths, 0);
        do_start();
        pulses(100);
        chk("t6_tenths_borrow", {secTens, secOnes, tenths}, 12'h009);
        pulses(899);
        chk("t6_no_done_early", done, 0);
        pulses(1);
        chk("t6_done", done, 1);
        chk("t6_zero", {secTens, secOnes, tenths}, 12'h000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
